// File: rtl/sr_cmd_driver.sv
// Drives set/reset pulses into a bank of SR flops until their readback matches the
// requested levels, retrying mismatched bits a bounded number of times.
module sr_cmd_driver #(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_level,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask,
  output logic [2:0]       dbg_state
);

  // Handshake: a request transfers on any posedge where req_valid and req_ready are
  // both 1; req_ready is high only in IDLE, so at most one request is in flight.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PULSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [RW-1:0]     retry_q;
  logic [WIDTH-1:0]  tgt_q;
  logic [WIDTH-1:0]  s_q, r_q, err_mask_q;
  logic              req_ready_q, busy_q, done_q, err_q;

  logic [WIDTH-1:0]  tgt_src_d, set_d, clr_d, mis_d;

  // In IDLE the masks come from the incoming level; afterwards from the captured target.
  always_comb begin
    tgt_src_d = (state_q == ST_IDLE) ? req_level : tgt_q;
    set_d     = tgt_src_d & ~q_fb;
    clr_d     = ~tgt_src_d & q_fb;
    mis_d     = q_fb ^ tgt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      tgt_q       <= '0;
      s_q         <= '0;
      r_q         <= '0;
      err_mask_q  <= '0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            tgt_q       <= req_level;
            err_mask_q  <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if ((set_d | clr_d) == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_PULSE;
              s_q     <= set_d;
              r_q     <= clr_d;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
            s_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
            cnt_q <= '0;
            if (mis_d == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (retry_q < RW'(MAX_RETRY)) begin
              // Only the bits still wrong are re-pulsed.
              retry_q <= retry_q + RW'(1);
              s_q     <= set_d;
              r_q     <= clr_d;
              state_q <= ST_PULSE;
            end else begin
              err_mask_q <= mis_d;
              err_q      <= 1'b1;
              state_q    <= ST_ERROR;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE, ST_ERROR: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          s_q     <= '0;
          r_q     <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: an SR flop bank model closes the loop; directed request
// vectors with hand-computed pulses, latencies and final levels.
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_level;
  logic [7:0] s, r, q_fb, err_mask;
  logic       busy, done, err;
  logic [2:0] dbg_state;

  logic [7:0] q_m   = 8'h00;
  logic [7:0] stuck = 8'h00;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] lvl;
    logic [7:0] es;
    logic [7:0] er;
    logic [7:0] stk;
    logic [7:0] exp_q;
    logic [7:0] exp_mask;
    int         lat;
    bit         exp_err;
    int         pulses;
    int         unstick_j;
  } vec_t;

  vec_t vecs[7];

  sr_cmd_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_level (req_level),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_mask  (err_mask),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // SR flop bank; stuck bits are held at 0 regardless of pulses.
  always @(posedge clk) q_m <= ((q_m | s) & ~r) & ~stuck;
  assign q_fb = q_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input int id, input vec_t v);
    int   t;
    int   done_at, err_at, done_n, err_n, pcyc;
    logic ovl;
    done_at = -1; err_at = -1; done_n = 0; err_n = 0; pcyc = 0; ovl = 1'b0;
    stuck = v.stk;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("v%0d_ready", id), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_level = v.lvl;
    @(posedge clk);
    for (int j = 0; j <= v.lat + 1; j++) begin
      @(negedge clk);
      if (done) begin done_n++; done_at = j; end
      if (err)  begin err_n++;  err_at  = j; end
      if ((s | r) != 8'h00) pcyc++;
      if ((s & r) != 8'h00) ovl = 1'b1;
      if (j == 0) begin
        chk($sformatf("v%0d_s0", id), {24'd0, s}, {24'd0, v.es});
        chk($sformatf("v%0d_r0", id), {24'd0, r}, {24'd0, v.er});
        chk($sformatf("v%0d_busy0", id), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_noready0", id), {31'd0, req_ready}, 32'd0);
        // Hold valid and scramble the level: neither may disturb the request in flight.
        req_level = ~v.lvl;
      end
      if (j == 1) req_valid = 1'b0;
      if (j == v.unstick_j) stuck = 8'h00;
      if (j == v.lat + 1) begin
        chk($sformatf("v%0d_ready_end", id), {31'd0, req_ready}, 32'd1);
        chk($sformatf("v%0d_idle_end", id), {31'd0, busy}, 32'd0);
      end
    end
    chk($sformatf("v%0d_done_at", id), done_at, v.exp_err ? -1 : v.lat);
    chk($sformatf("v%0d_done_n", id), done_n, v.exp_err ? 0 : 1);
    chk($sformatf("v%0d_err_at", id), err_at, v.exp_err ? v.lat : -1);
    chk($sformatf("v%0d_err_n", id), err_n, v.exp_err ? 1 : 0);
    chk($sformatf("v%0d_pulse_cycles", id), pcyc, v.pulses * 2);
    chk($sformatf("v%0d_s_r_overlap", id), {31'd0, ovl}, 32'd0);
    chk($sformatf("v%0d_q", id), {24'd0, q_m}, {24'd0, v.exp_q});
    chk($sformatf("v%0d_err_mask", id), {24'd0, err_mask}, {24'd0, v.exp_mask});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vf;
    logic seen;
    //          lvl    es     er     stk    exp_q  mask   lat err p  unstick
    vecs[0] = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 4,  0, 1, -1};
    vecs[1] = '{8'h5A, 8'h5A, 8'hA5, 8'h00, 8'h5A, 8'h00, 4,  0, 1, -1};
    vecs[2] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 0,  0, 0, -1};
    vecs[3] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 4,  0, 1, -1};
    vecs[4] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 16, 1, 4, -1};
    vecs[5] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 4,  0, 1, -1};
    vecs[6] = '{8'h80, 8'h80, 8'h0F, 8'h80, 8'h80, 8'h00, 8,  0, 2, 5};

    // Reset held with a pending request.
    rst_n = 1'b0; req_valid = 1'b1; req_level = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_s", {24'd0, s}, 32'd0);
    chk("rst_r", {24'd0, r}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_mask", {24'd0, err_mask}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after_1edge", {31'd0, req_ready}, 32'd1);
    chk("rst_no_accept", {31'd0, busy}, 32'd0);
    req_valid = 1'b0;

    for (int i = 0; i < 7; i++) do_req(i, vecs[i]);

    // Reset in the middle of a pulse.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_level = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_s_before", {24'd0, s}, 32'h7F);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_s", {24'd0, s}, 32'd0);
    chk("midrst_r", {24'd0, r}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    chk("midrst_no_done_err", {31'd0, seen}, 32'd0);
    chk("midrst_q_kept", {24'd0, q_m}, 32'h80);

    vf = '{8'hFF, 8'h7F, 8'h00, 8'h00, 8'hFF, 8'h00, 4, 0, 1, -1};
    do_req(7, vf);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
